// File: rtl/port_bus_bridge.sv
// port_bus_bridge: serial-command initiator for the 16-bit port bus.
// Decodes 'W' AH AL DH DL (bus write) and 'R' AH AL (bus read) from UART
// receive bytes, runs the bus cycle, and returns 'K', the two read data
// bytes, or '?' for an unknown command through the UART transmit path.
module port_bus_bridge #(
   parameter int unsigned TO_CYCLES = 500000,
   parameter int unsigned TO_W      = 20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        tx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_write,
   output logic [15:0] PORT_ID,
   output logic [15:0] OUT_PORT,
   input  logic [15:0] IN_PORT,
   output logic        READ_STROBE,
   output logic        WRITE_STROBE,
   output logic        busy
);

   typedef enum logic [3:0] {
      IDLE,
      GET_AH,
      GET_AL,
      GET_DH,
      GET_DL,
      BUS_WR,
      BUS_RD1,
      BUS_RD2,
      SEND,
      GUARD
   } state_t;

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] RSP_ACK   = 8'h4B;
   localparam logic [7:0] RSP_ERR   = 8'h3F;

   // Abort is taken on the edge where the counter would reach TO_CYCLES,
   // so a command stalls for exactly TO_CYCLES cycles before dropping.
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

   state_t          state;
   logic            op_wr;
   logic [7:0]      addr_hi;
   logic [7:0]      addr_lo;
   logic [7:0]      data_hi;
   logic [7:0]      resp0;
   logic [7:0]      resp1;
   logic [1:0]      resp_cnt;
   logic [1:0]      tx_idx;
   logic            guard_cnt;
   logic [TO_W-1:0] to_cnt;

   // Command FSM with registered bus, transmit and busy outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         op_wr        <= 1'b0;
         addr_hi      <= '0;
         addr_lo      <= '0;
         data_hi      <= '0;
         resp0        <= '0;
         resp1        <= '0;
         resp_cnt     <= '0;
         tx_idx       <= '0;
         guard_cnt    <= 1'b0;
         to_cnt       <= '0;
         tx_data      <= '0;
         tx_write     <= 1'b0;
         PORT_ID      <= '0;
         OUT_PORT     <= '0;
         READ_STROBE  <= 1'b0;
         WRITE_STROBE <= 1'b0;
         busy         <= 1'b0;
      end else begin
         tx_write <= 1'b0;
         case (state)
            IDLE: begin
               to_cnt <= '0;
               if (rx_valid) begin
                  busy <= 1'b1;
                  if (rx_data == CMD_WRITE) begin
                     op_wr <= 1'b1;
                     state <= GET_AH;
                  end else if (rx_data == CMD_READ) begin
                     op_wr <= 1'b0;
                     state <= GET_AH;
                  end else begin
                     resp0    <= RSP_ERR;
                     resp_cnt <= 2'd1;
                     tx_idx   <= '0;
                     state    <= SEND;
                  end
               end
            end

            GET_AH: begin
               if (to_cnt == TO_LAST) begin
                  to_cnt <= '0;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end else if (rx_valid) begin
                  addr_hi <= rx_data;
                  to_cnt  <= '0;
                  state   <= GET_AL;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end

            GET_AL: begin
               if (to_cnt == TO_LAST) begin
                  to_cnt <= '0;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end else if (rx_valid) begin
                  addr_lo <= rx_data;
                  to_cnt  <= '0;
                  if (op_wr) begin
                     state <= GET_DH;
                  end else begin
                     PORT_ID     <= {addr_hi, rx_data};
                     READ_STROBE <= 1'b1;
                     state       <= BUS_RD1;
                  end
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end

            GET_DH: begin
               if (to_cnt == TO_LAST) begin
                  to_cnt <= '0;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end else if (rx_valid) begin
                  data_hi <= rx_data;
                  to_cnt  <= '0;
                  state   <= GET_DL;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end

            GET_DL: begin
               if (to_cnt == TO_LAST) begin
                  to_cnt <= '0;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end else if (rx_valid) begin
                  PORT_ID      <= {addr_hi, addr_lo};
                  OUT_PORT     <= {data_hi, rx_data};
                  WRITE_STROBE <= 1'b1;
                  to_cnt       <= '0;
                  state        <= BUS_WR;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end

            BUS_WR: begin
               WRITE_STROBE <= 1'b0;
               resp0        <= RSP_ACK;
               resp_cnt     <= 2'd1;
               tx_idx       <= '0;
               state        <= SEND;
            end

            BUS_RD1: begin
               state <= BUS_RD2;
            end

            BUS_RD2: begin
               READ_STROBE <= 1'b0;
               resp0       <= IN_PORT[15:8];
               resp1       <= IN_PORT[7:0];
               resp_cnt    <= 2'd2;
               tx_idx      <= '0;
               state       <= SEND;
            end

            SEND: begin
               if (tx_idx == resp_cnt) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (tx_ready) begin
                  tx_data   <= (tx_idx == 2'd0) ? resp0 : resp1;
                  tx_write  <= 1'b1;
                  tx_idx    <= tx_idx + 2'd1;
                  guard_cnt <= 1'b0;
                  state     <= GUARD;
               end
            end

            GUARD: begin
               if (guard_cnt) begin
                  state <= SEND;
               end else begin
                  guard_cnt <= 1'b1;
               end
            end

            default: begin
               READ_STROBE  <= 1'b0;
               WRITE_STROBE <= 1'b0;
               busy         <= 1'b0;
               state        <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_port_bus_bridge.sv
// Table-driven bench for port_bus_bridge with a small port/RAM model.
module tb_port_bus_bridge;

   logic        clk;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        tx_ready;
   logic [7:0]  tx_data;
   logic        tx_write;
   logic [15:0] PORT_ID;
   logic [15:0] OUT_PORT;
   logic [15:0] IN_PORT;
   logic        READ_STROBE;
   logic        WRITE_STROBE;
   logic        busy;

   port_bus_bridge #(.TO_CYCLES(16), .TO_W(5)) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .tx_ready     (tx_ready),
      .tx_data      (tx_data),
      .tx_write     (tx_write),
      .PORT_ID      (PORT_ID),
      .OUT_PORT     (OUT_PORT),
      .IN_PORT      (IN_PORT),
      .READ_STROBE  (READ_STROBE),
      .WRITE_STROBE (WRITE_STROBE),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bus model: RAM at bit15=1 with one-cycle read latency, other ports
   // return {A5, low address byte}.
   logic [15:0] ram [0:255];
   always @(posedge clk) begin
      if (WRITE_STROBE && PORT_ID[15]) ram[PORT_ID[7:0]] <= OUT_PORT;
      if (READ_STROBE)
         IN_PORT <= PORT_ID[15] ? ram[PORT_ID[7:0]] : {8'hA5, PORT_ID[7:0]};
   end

   // Activity monitor (monotonic totals, tests compare deltas).
   int          cyc;
   int          wr_total;
   int          rd_total;
   int          tx_total;
   logic [15:0] wr_addr;
   logic [15:0] wr_data;
   logic [15:0] rd_addr;
   logic [7:0]  tx_log [0:255];
   int          tx_cyc [0:255];
   initial begin
      cyc = 0; wr_total = 0; rd_total = 0; tx_total = 0;
      wr_addr = '0; wr_data = '0; rd_addr = '0;
   end
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (WRITE_STROBE) begin
         wr_total = wr_total + 1;
         wr_addr  = PORT_ID;
         wr_data  = OUT_PORT;
      end
      if (READ_STROBE) begin
         rd_total = rd_total + 1;
         rd_addr  = PORT_ID;
      end
      if (tx_write && tx_total < 256) begin
         tx_log[tx_total] = tx_data;
         tx_cyc[tx_total] = cyc;
         tx_total = tx_total + 1;
      end
   end

   int n_pass;
   int n_total;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total = n_total + 1;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      else
         n_pass = n_pass + 1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1;
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_data  = '0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'd0, busy}, 32'd0);
   endtask

   typedef struct {
      logic [39:0] bytes;
      int          nbytes;
      int          exp_wr;
      int          exp_rd;
      logic [15:0] exp_addr;
      logic [15:0] exp_wdata;
      int          exp_ntx;
      logic [15:0] exp_tx;
   } vec_t;

   vec_t vecs [6];

   int b_wr, b_rd, b_tx;

   task automatic snap();
      b_wr = wr_total;
      b_rd = rd_total;
      b_tx = tx_total;
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      rx_data  = '0;
      rx_valid = 1'b0;
      tx_ready = 1'b1;
      reset    = 1'b0;

      vecs[0] = '{40'h57_80_10_BE_EF, 5, 1, 0, 16'h8010, 16'hBEEF, 1, 16'h4B00};
      vecs[1] = '{40'h52_80_10_00_00, 3, 0, 2, 16'h8010, 16'h0000, 2, 16'hBEEF};
      vecs[2] = '{40'h41_00_00_00_00, 1, 0, 0, 16'h0000, 16'h0000, 1, 16'h3F00};
      vecs[3] = '{40'h57_00_05_12_34, 5, 1, 0, 16'h0005, 16'h1234, 1, 16'h4B00};
      vecs[4] = '{40'h52_00_05_00_00, 3, 0, 2, 16'h0005, 16'h0000, 2, 16'hA505};
      vecs[5] = '{40'h57_80_FF_C3_3C, 5, 1, 0, 16'h80FF, 16'hC33C, 1, 16'h4B00};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_port_id", {16'd0, PORT_ID}, 32'd0);
      check("rst_out_port", {16'd0, OUT_PORT}, 32'd0);
      check("rst_strobes", {30'd0, READ_STROBE, WRITE_STROBE}, 32'd0);
      check("rst_tx", {23'd0, tx_write, tx_data}, 32'd0);
      reset = 1'b1;

      // Table-driven commands
      for (int v = 0; v < 6; v++) begin
         snap();
         for (int i = 0; i < vecs[v].nbytes; i++) begin
            logic [39:0] bs;
            bs = vecs[v].bytes;
            send_byte(bs[39 - 8*i -: 8]);
         end
         wait_idle("vec_idle");
         check("vec_wr_cnt", wr_total - b_wr, vecs[v].exp_wr);
         check("vec_rd_cnt", rd_total - b_rd, vecs[v].exp_rd);
         if (vecs[v].exp_wr != 0) begin
            check("vec_wr_addr", {16'd0, wr_addr}, {16'd0, vecs[v].exp_addr});
            check("vec_wr_data", {16'd0, wr_data}, {16'd0, vecs[v].exp_wdata});
         end
         if (vecs[v].exp_rd != 0)
            check("vec_rd_addr", {16'd0, rd_addr}, {16'd0, vecs[v].exp_addr});
         check("vec_ntx", tx_total - b_tx, vecs[v].exp_ntx);
         if (tx_total - b_tx == vecs[v].exp_ntx) begin
            check("vec_tx0", {24'd0, tx_log[b_tx]}, {24'd0, vecs[v].exp_tx[15:8]});
            if (vecs[v].exp_ntx == 2) begin
               check("vec_tx1", {24'd0, tx_log[b_tx+1]}, {24'd0, vecs[v].exp_tx[7:0]});
               check("vec_tx_gap_ge3",
                     {31'd0, (tx_cyc[b_tx+1] - tx_cyc[b_tx]) >= 3}, 32'd1);
            end
         end
      end

      // Read back RAM written by vector 5
      snap();
      send_byte(8'h52); send_byte(8'h80); send_byte(8'hFF);
      wait_idle("rb_idle");
      check("rb_ntx", tx_total - b_tx, 2);
      check("rb_tx0", {24'd0, tx_log[b_tx]}, 32'h0000_00C3);
      check("rb_tx1", {24'd0, tx_log[b_tx+1]}, 32'h0000_003C);

      // Write strobe latency: high the cycle after DL, exactly one cycle
      snap();
      send_byte(8'h57); send_byte(8'h80); send_byte(8'h30); send_byte(8'hAA);
      check("wl_before", {31'd0, WRITE_STROBE}, 32'd0);
      send_byte(8'h55);
      check("wl_strobe_hi", {31'd0, WRITE_STROBE}, 32'd1);
      check("wl_port_id", {16'd0, PORT_ID}, 32'h0000_8030);
      check("wl_out_port", {16'd0, OUT_PORT}, 32'h0000_AA55);
      check("wl_no_tx_yet", tx_total - b_tx, 0);
      @(posedge clk);
      #1;
      check("wl_strobe_lo", {31'd0, WRITE_STROBE}, 32'd0);
      wait_idle("wl_idle");
      check("wl_tx_k", {24'd0, tx_log[b_tx]}, 32'h0000_004B);

      // Read strobe: high for the two cycles after AL
      snap();
      send_byte(8'h52); send_byte(8'h80);
      send_byte(8'h30);
      check("rl_rd1", {31'd0, READ_STROBE}, 32'd1);
      @(posedge clk); #1;
      check("rl_rd2", {31'd0, READ_STROBE}, 32'd1);
      @(posedge clk); #1;
      check("rl_rd_off", {31'd0, READ_STROBE}, 32'd0);
      wait_idle("rl_idle");
      check("rl_data", {16'd0, tx_log[b_tx], tx_log[b_tx+1]}, 32'h0000_AA55);

      // Timeout after a partial command
      snap();
      send_byte(8'h57); send_byte(8'h00);
      repeat (15) @(posedge clk);
      #1;
      check("to_busy_before", {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1;
      check("to_busy_after", {31'd0, busy}, 32'd0);
      repeat (5) @(posedge clk);
      #1;
      check("to_no_wr", wr_total - b_wr, 0);
      check("to_no_tx", tx_total - b_tx, 0);
      snap();
      send_byte(8'h52); send_byte(8'h00); send_byte(8'h03);
      wait_idle("to_rd_idle");
      check("to_rd_cnt", rd_total - b_rd, 2);
      check("to_rd_data", {16'd0, tx_log[b_tx], tx_log[b_tx+1]}, 32'h0000_A503);

      // Backpressure: no transmit while tx_ready is low, late bytes dropped
      snap();
      tx_ready = 1'b0;
      send_byte(8'h52); send_byte(8'h80); send_byte(8'h10);
      repeat (50) @(posedge clk);
      #1;
      check("bp_no_tx", tx_total - b_tx, 0);
      check("bp_busy", {31'd0, busy}, 32'd1);
      send_byte(8'h41);
      #1;
      tx_ready = 1'b1;
      wait_idle("bp_idle");
      repeat (10) @(posedge clk);
      #1;
      check("bp_ntx", tx_total - b_tx, 2);
      check("bp_data", {16'd0, tx_log[b_tx], tx_log[b_tx+1]}, 32'h0000_BEEF);
      check("bp_gap_ge3", {31'd0, (tx_cyc[b_tx+1] - tx_cyc[b_tx]) >= 3}, 32'd1);
      check("bp_busy_end", {31'd0, busy}, 32'd0);

      // Asynchronous reset mid-command
      send_byte(8'h57); send_byte(8'h12); send_byte(8'h34);
      reset = 1'b0;
      #1;
      check("mr_busy", {31'd0, busy}, 32'd0);
      check("mr_port_id", {16'd0, PORT_ID}, 32'd0);
      check("mr_out_port", {16'd0, OUT_PORT}, 32'd0);
      check("mr_tx", {23'd0, tx_write, tx_data}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      snap();
      send_byte(8'h52); send_byte(8'h00); send_byte(8'h01);
      wait_idle("mr_idle");
      check("mr_no_wr", wr_total - b_wr, 0);
      check("mr_rd_addr", {16'd0, rd_addr}, 32'h0000_0001);
      check("mr_ntx", tx_total - b_tx, 2);
      check("mr_data", {16'd0, tx_log[b_tx], tx_log[b_tx+1]}, 32'h0000_A501);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/port_bus_bridge.md
# port_bus_bridge

Serial-command initiator for the 16-bit port bus: consumes bytes from the UART receive path, decodes write/read commands, and drives PORT_ID/OUT_PORT/READ_STROBE/WRITE_STROBE exactly as the CPU does. Read data and acknowledgements go back as bytes to the UART transmit path. It sits beside the CPU as a debug/host master on the same decoder and static RAM.

## Interface
- TO_CYCLES, 500000, inter-byte timeout in clk cycles while a command is partially received.
- TO_W, 20, timeout counter width; must hold TO_CYCLES.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- rx_data  in  8  received byte; valid only while rx_valid=1.
- rx_valid  in  1  one-cycle strobe per received byte.
- tx_ready  in  1  transmitter idle and able to accept a byte.
- tx_data  out  8  byte to transmit; held stable from its tx_write pulse until the next pulse.
- tx_write  out  1  one-cycle load strobe to the transmitter.
- PORT_ID  out  16  bus address; bit 15 selects static RAM.
- OUT_PORT  out  16  bus write data.
- IN_PORT  in  16  bus read data.
- READ_STROBE  out  1  bus read strobe.
- WRITE_STROBE  out  1  bus write strobe.
- busy  out  1  high in every state except IDLE.

## Operation
- Command format (bytes, MSB first): write = 0x57 'W', AH, AL, DH, DL; read = 0x52 'R', AH, AL.
- Responses: write -> 0x4B 'K'; read -> DH, DL of sampled IN_PORT; unrecognised first byte -> 0x3F '?'.
- States: IDLE, GET_AH, GET_AL, GET_DH, GET_DL, BUS_WR, BUS_RD1, BUS_RD2, SEND, GUARD.
- IDLE: on rx_valid, 'W' -> GET_AH (op=write); 'R' -> GET_AH (op=read); else load 0x3F into response slot 0, count=1 -> SEND.
- GET_AH/GET_AL: capture address bytes on rx_valid. After AL: read -> BUS_RD1; write -> GET_DH.
- GET_DH/GET_DL: capture data bytes; after DL -> BUS_WR.
- BUS_WR: PORT_ID=addr, OUT_PORT=data, WRITE_STROBE=1 for exactly one cycle; response 0x4B, count=1 -> SEND.
- BUS_RD1, BUS_RD2: PORT_ID=addr, READ_STROBE=1 both cycles (covers the one-cycle synchronous RAM latency); IN_PORT sampled at end of BUS_RD2; response {DH,DL}, count=2 -> SEND.
- SEND: when tx_ready=1, pulse tx_write with the next response byte -> GUARD. When all bytes sent -> IDLE.
- GUARD: two cycles, tx_ready ignored (transmitter drops ready after load), then back to SEND.
- PORT_ID/OUT_PORT hold their last driven value outside bus states; strobes are 0 outside BUS states.
- Timeout: counter cleared on every accepted byte and in IDLE; increments in GET_* states; on reaching TO_CYCLES -> IDLE silently, no bus cycle, no response.
- rx_valid in BUS_*, SEND, GUARD: byte discarded (no queueing).

## Timing
- Reset (reset=0): state IDLE, all outputs 0, counter 0, response slots 0; takes effect immediately, including mid-command or mid-SEND (a pending tx_write is not issued).
- Write: WRITE_STROBE asserted the cycle after the DL rx_valid cycle; first tx_write no earlier than the following cycle (when tx_ready=1).
- Read: READ_STROBE high the 2 cycles after the AL rx_valid cycle; first tx_write no earlier than the cycle after BUS_RD2.
- Min spacing between tx_write pulses: 3 cycles (pulse + 2 GUARD).
- tx_ready held 0 indefinitely: block stays in SEND; no timeout applies in SEND.
- Timeout boundary: byte arriving in the same cycle the counter reaches TO_CYCLES is discarded; abort wins.

## Test plan
- Write: bytes 57 80 10 BE EF -> one-cycle WRITE_STROBE with PORT_ID=0x8010, OUT_PORT=0xBEEF; then tx_write with tx_data=0x4B; busy returns 0.
- Read after write: bytes 52 80 10 with RAM model (1-cycle latency) -> READ_STROBE 2 cycles at 0x8010; tx bytes 0xBE then 0xEF, pulses ≥3 cycles apart.
- Unknown command: byte 0x41 -> no strobes; single tx byte 0x3F.
- Timeout (TO_CYCLES=16): bytes 57 00 then silence -> IDLE after 16 cycles, no strobe, no tx; following 52 00 03 performs a normal read.
- Backpressure: hold tx_ready=0 for 50 cycles after a read -> no tx_write; release -> both bytes sent in order; bytes received during SEND are ignored.
- Reset mid-operation: assert reset after 57 12 34 -> all outputs 0 immediately; after release, new command 52 00 01 executes correctly.
